// File: rtl/exec_control.sv
// Fetch/decode/execute sequencer for the 8-bit ALU: owns pc, a 4x8 register file
// and the Z/C flags; reads a synchronous ROM, drives the ALU and writes results back.
module exec_control #(
   parameter logic [7:0] PC_RESET = 8'h00
) (
   input  logic       clk,
   input  logic       reset,
   output logic [7:0] instr_addr,
   input  logic [7:0] instr_data,
   output logic [7:0] alu_in1,
   output logic [7:0] alu_in2,
   output logic [2:0] alu_mode,
   input  logic [7:0] alu_out,
   input  logic       alu_flag_zero,
   input  logic       alu_flag_carry,
   output logic       flag_z,
   output logic       flag_c,
   output logic       instr_done,
   output logic       halted,
   input  logic [1:0] dbg_sel,
   output logic [7:0] dbg_data,
   output logic [2:0] dbg_state
);

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_FETCH2 = 3'd3;
   localparam logic [2:0] S_IMM    = 3'd4;
   localparam logic [2:0] S_HALT   = 3'd5;

   logic [2:0] state;
   logic [7:0] pc;
   logic [3:0] ir_op;
   logic [1:0] ir_a;
   logic [7:0] regs [4];

   // Fields of the byte arriving from the ROM during DECODE
   logic [3:0] d_op;
   logic [1:0] d_a;
   logic [1:0] d_b;
   logic [7:0] d_simm;
   logic [2:0] d_mode;
   logic       d_single;

   assign d_op     = instr_data[7:4];
   assign d_a      = instr_data[3:2];
   assign d_b      = instr_data[1:0];
   assign d_simm   = {{6{d_b[1]}}, d_b};
   assign d_single = (d_op == 4'h7) || (d_op == 4'hC) || (d_op == 4'hD) || (d_op == 4'hE);

   always_comb begin
      d_mode = 3'b000;
      case (d_op)
         4'h1:    d_mode = 3'b001;
         4'h2:    d_mode = 3'b010;
         4'h3:    d_mode = 3'b011;
         4'h4:    d_mode = 3'b100;
         4'h5:    d_mode = 3'b101;
         default: d_mode = 3'b000;
      endcase
   end

   assign instr_addr = pc;
   assign halted     = (state == S_HALT);
   assign dbg_data   = regs[dbg_sel];
   assign dbg_state  = state;
   assign instr_done = (state == S_EXEC) || (state == S_IMM) ||
                       ((state == S_DECODE) && d_single);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_FETCH;
         pc       <= PC_RESET;
         ir_op    <= 4'h0;
         ir_a     <= 2'd0;
         flag_z   <= 1'b0;
         flag_c   <= 1'b0;
         alu_in1  <= 8'd0;
         alu_in2  <= 8'd0;
         alu_mode <= 3'b000;
         for (int i = 0; i < 4; i++) regs[i] <= 8'd0;
      end else begin
         case (state)
            S_FETCH: state <= S_DECODE;
            S_DECODE: begin
               ir_op <= d_op;
               ir_a  <= d_a;
               pc    <= pc + 8'd1;
               case (d_op)
                  4'h0, 4'h2, 4'h3, 4'h4, 4'h5: begin
                     alu_in1  <= regs[d_a];
                     alu_in2  <= regs[d_b];
                     alu_mode <= d_mode;
                     state    <= S_EXEC;
                  end
                  // ALU subtracts in1 from in2, so the operands swap for Ra-Rb
                  4'h1: begin
                     alu_in1  <= regs[d_b];
                     alu_in2  <= regs[d_a];
                     alu_mode <= d_mode;
                     state    <= S_EXEC;
                  end
                  4'h6: begin
                     alu_in1  <= regs[d_a];
                     alu_in2  <= d_simm;
                     alu_mode <= d_mode;
                     state    <= S_EXEC;
                  end
                  4'h7: begin
                     regs[d_a] <= regs[d_b];
                     state     <= S_FETCH;
                  end
                  4'h8, 4'h9, 4'hA, 4'hB: state <= S_FETCH2;
                  4'hF:                   state <= S_HALT;
                  default:                state <= S_FETCH;
               endcase
            end
            S_EXEC: begin
               if (ir_op != 4'h2) regs[ir_a] <= alu_out;
               flag_z <= alu_flag_zero;
               // Logic ops leave carry alone
               if ((ir_op <= 4'h2) || (ir_op == 4'h6)) flag_c <= alu_flag_carry;
               state <= S_FETCH;
            end
            S_FETCH2: state <= S_IMM;
            S_IMM: begin
               pc <= pc + 8'd1;
               case (ir_op)
                  4'h8: pc <= instr_data;
                  4'h9: if (flag_z) pc <= instr_data;
                  4'hA: if (flag_c) pc <= instr_data;
                  4'hB: regs[ir_a] <= instr_data;
                  default: ;
               endcase
               state <= S_FETCH;
            end
            S_HALT:  state <= S_HALT;
            default: state <= S_FETCH;
         endcase
      end
   end

endmodule

// File: doc/exec_control.md
Name: exec_control

Overview:
- Multi-cycle fetch/decode/execute sequencer that sits directly upstream of the 8-bit ALU.
- Owns the program counter, a 4x8 register file and the architectural Z/C flag register.
- Fetches bytes from a synchronous instruction ROM, drives ALU operands and mode, then writes the ALU result and flags back.

Parameters:
- PC_RESET, 8'h00, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- instr_addr  out  8  ROM address; continuously equals pc.
- instr_data  in  8  ROM data; synchronous ROM, valid one cycle after address.
- alu_in1  out  8  ALU operand 1 (registered).
- alu_in2  out  8  ALU operand 2 (registered).
- alu_mode  out  3  ALU mode (registered).
- alu_out  in  8  ALU result (combinational from operands).
- alu_flag_zero  in  1  ALU zero flag.
- alu_flag_carry  in  1  ALU carry / greater-than flag.
- flag_z  out  1  architectural zero flag.
- flag_c  out  1  architectural carry flag.
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction.
- halted  out  1  high in HALT state.
- dbg_sel  in  2  register-file debug read select.
- dbg_data  out  8  combinational R[dbg_sel].

Behaviour:
- Reset (async, immediate, also mid-instruction):
  - pc=PC_RESET; R0..R3=0; flag_z=flag_c=0.
  - alu_in1=alu_in2=0; alu_mode=000; instr_done=0; halted=0; state=FETCH.
- Instruction byte IR: op=IR[7:4], a=IR[3:2], b=IR[1:0].
  - simm = sign-extended b (00->0, 01->1, 10->-2, 11->-1).
- Opcodes:
  - 0 ADD: Ra=Ra+Rb.
  - 1 SUB: Ra=Ra-Rb; ALU computes In2-In1, so in1=Rb, in2=Ra.
  - 2 CMP: in1=Ra, in2=Rb; no writeback; Z=(Ra==Rb); C=(Ra>Rb).
  - 3 AND, 4 OR, 5 XOR: Ra=Ra op Rb.
  - 6 ADDI: Ra=Ra+simm.
  - 7 MOV: Ra=Rb, no ALU, flags unchanged.
  - 8 JMP t, 9 JZ t, A JC t, B LDI Ra,t: two-byte instructions; second byte is t.
  - F HALT.
  - C,D,E: NOP.
- ALU mode mapping:
  - ADD and ADDI use 000; SUB uses 001; CMP uses 010.
  - AND uses 011, OR uses 100, XOR uses 101.
- States:
  - FETCH: pc is on instr_addr -> DECODE.
  - DECODE: IR<=instr_data; pc<=pc+1.
    - op 0-6: load alu_in1/alu_in2/alu_mode -> EXEC.
    - MOV and NOP: perform the op, pulse instr_done -> FETCH.
    - op 8-B -> FETCH2.
    - HALT -> HALT.
  - FETCH2: addr = incremented pc -> IMM.
  - IMM: t<=instr_data; pc<=pc+1, except where overridden:
    - JMP: pc<=t.
    - JZ: pc<=t if flag_z.
    - JC: pc<=t if flag_c.
    - LDI: Ra<=t.
    - Then pulse instr_done -> FETCH.
  - EXEC: ALU inputs are stable; sample alu_out and the flags.
    - Write Ra for all ops except CMP.
    - ADD/SUB/ADDI: Z<=alu_flag_zero, C<=alu_flag_carry.
    - AND/OR/XOR: Z<=alu_flag_zero; C unchanged.
    - CMP: Z and C from the ALU.
    - Pulse instr_done -> FETCH.
  - HALT: terminal; halted=1, no fetch, pc frozen; exit only via reset.
- Latency:
  - ALU ops: 3 cycles (FETCH, DECODE, EXEC).
  - MOV/NOP: 2 cycles.
  - Two-byte instructions: 4 cycles.
  - First instr_done for an ALU op: 3rd rising edge after reset release.
- Boundaries:
  - pc wraps 8'hFF -> 8'h00, including the second-byte fetch.
  - a==b is legal: ADD R1,R1 doubles; SUB gives 0 and Z=1.
  - Carry on ADD is bit 8 of the 9-bit sum. On SUB it is bit 8 of the 9-bit difference, i.e. 1 when borrowing.
  - Operands hold their last values outside EXEC.
  - dbg_data reflects a write from the cycle after the capturing edge.

Test Plan:
- Reset, then ROM {B0,C8, B4,40, 01}: R0=C8, R1=40, then ADD R0,R1 -> R0=08, C=1, Z=0; instr_done pulses 3 times; ADD takes 3 cycles.
- LDI R2,05; LDI R3,05; SUB R2,R3 (0x1B) -> R2=00, Z=1, C=0; then SUB R2,R3 again -> R2=FB, C=1.
- LDI R0,07; ADDI R0,-1 (0x63) -> R0=06; ADDI R0,-2 (0x62) -> R0=04; C=1 on both (-1 = +FF, -2 = +FE).
- CMP R0,R1 with R0=09, R1=03 -> Z=0, C=1, R0 unchanged; then JC 20 -> pc=20; with C=0, JC falls through to pc+2.
- Program HALT (F0) at 10 -> halted=1, pc=11 frozen for 20 cycles; assert reset during EXEC of a later run -> all outputs return to reset values immediately, with no register write.
- PC_RESET=FE, ROM[FE]=80, ROM[FF]=00 (JMP 00) -> second byte is fetched from FF, then pc=00; with ROM[FF]=B0 as LDI at FF, the operand byte is fetched from 00.
